mario_sprite_fetch: RTL and testbench
=====================================

Name: mario_sprite_fetch

Overview:
- Pixel-pipeline stage directly upstream of color_mapper.
- Inputs: VGA scan position (DrawX/DrawY) and Mario's game state (position, facing, animation frame, visibility).
- Output: per-pixel "mario" hit flag plus 24-bit RGB (mario_pic_out), with DrawX/DrawY delayed to match.
- Game state is latched once per frame so the sprite never tears mid-scan.

Parameters:
- SPR_W, 16, sprite width in pixels (power of two).
- SPR_H, 16, sprite height in pixels (power of two).
- NUM_FRAMES, 4, animation frames stored in ROM.
- LATENCY, 2, fixed pipeline depth (documentation constant; not overridable).

Ports:
- Clk  input  1  pixel clock; one DrawX/DrawY pair per cycle.
- Reset_n  input  1  asynchronous, active-low reset.
- frame_start  input  1  one-cycle pulse from VGA controller at start of vertical blank.
- DrawX  input  10  current scan column.
- DrawY  input  10  current scan row.
- mario_x  input  10  sprite left edge, screen pixels.
- mario_y  input  10  sprite top edge, screen pixels.
- mario_flip  input  1  1 = mirror horizontally (facing left).
- mario_frame  input  2  animation frame index.
- mario_visible  input  1  0 = sprite hidden.
- mario  output  1  1 = opaque sprite pixel at DrawX_o/DrawY_o.
- mario_pic_out  output  24  RGB {R[23:16],G[15:8],B[7:0]}; 0 when mario=0.
- DrawX_o  output  10  DrawX delayed LATENCY cycles.
- DrawY_o  output  10  DrawY delayed LATENCY cycles.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - all outputs 0.
  - latched state: pos_x=0, pos_y=0, flip=0, frame=0, visible=0.
  - pipeline valid bits 0.
- Frame latch:
  - On Clk edge with frame_start=1, capture mario_x/y/flip/frame/visible into shadow regs.
  - Shadow regs hold until next frame_start.
  - Inputs changing between pulses have no effect.
- Stage 0 (combinational on inputs + shadow), all compares in 11 bits unsigned:
  - hit_x = DrawX >= pos_x && DrawX < pos_x+SPR_W.
  - hit_y likewise with SPR_H.
  - in_box = hit_x & hit_y & visible.
  - dx = DrawX-pos_x; dy = DrawY-pos_y.
  - col = flip ? SPR_W-1-dx : dx.
  - addr = frame*SPR_W*SPR_H + dy*SPR_W + col.
  - frame >= NUM_FRAMES is treated as frame 0.
- Stage 1 (registered):
  - ROM synchronous read of 4-bit palette index at addr.
  - in_box, DrawX, DrawY delayed alongside.
- Stage 2 (registered):
  - palette lookup: 16 entries × 24 bits; index 0 = transparent.
  - mario = in_box_d & (idx != 0).
  - mario_pic_out = mario ? palette[idx] : 24'h0.
  - DrawX_o/DrawY_o registered.
- Latency: exactly 2 cycles from DrawX/DrawY to aligned outputs; throughput 1 pixel/cycle, no stalls.
- Boundary conditions:
  - pos_x+SPR_W > 1023: sprite clipped at right edge, no wrap to column 0.
  - Same clipping rule applies to Y.
  - Out-of-box cycles: ROM address is don't-care, but mario must be 0.
  - frame_start coincident with an in-box pixel: the new state applies from the following cycle's Stage 0.
  - Reset mid-frame: outputs 0 immediately; sprite invisible until first frame_start after reset.

Decomposition:
- Shared package sprite_pkg holds:
  - typedef rgb_t (24-bit).
  - typedef pal_idx_t (4-bit).
  - SPR_W/SPR_H defaults.
  - TRANSPARENT_IDX = 0.
  - palette constant array.
  - LATENCY.
- Sub-module mario_sprite_rom:
  - synchronous single-port ROM, NUM_FRAMES*SPR_W*SPR_H × 4 bits.
  - initialized from a hex file.

Test Plan:
- Reset then scan full frame with no frame_start -> mario=0 everywhere, mario_pic_out=0, DrawX_o lags DrawX by 2.
- frame_start with mario_x=100, mario_y=200, visible=1, frame=0, flip=0 -> at DrawX=100, DrawY=200 the mario flag and RGB appear 2 cycles later, matching palette[rom[0]] (if nonzero). At DrawX=116 or DrawY=216 -> mario=0.
- Same position with flip=1 -> pixel at DrawX=100 shows ROM column 15; DrawX=115 shows column 0.
- mario_x=1020 -> hits only at DrawX 1020..1023; DrawX 0..11 on the same rows give mario=0.
- Change mario_x from 100 to 300 mid-frame without frame_start -> sprite stays at 100; after the next frame_start it appears at 300.
- ROM pixel index 0 inside box -> mario=0 and pic_out=0. Assert Reset_n=0 mid-sprite -> outputs 0 within the same cycle, sprite hidden until the next frame_start.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite types, palette and ROM image pattern for the Mario sprite pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pkg;

    localparam int SPR_W_DEF      = 16;
    localparam int SPR_H_DEF      = 16;
    localparam int NUM_FRAMES_DEF = 4;

    // Fixed pipeline depth from DrawX/DrawY to the aligned outputs.
    localparam int LATENCY = 2;

    typedef logic [23:0] rgb_t;
    typedef logic [3:0]  pal_idx_t;

    // Palette index reserved for "no sprite pixel here".
    localparam pal_idx_t TRANSPARENT_IDX = 4'd0;

    // 16-entry palette, {R,G,B}. Entry 0 is never displayed.
    localparam rgb_t PALETTE [16] = '{
        24'h000000, 24'hF83800, 24'hFFA044, 24'hAC7C00,
        24'h0058F8, 24'hFCE0A8, 24'h503000, 24'hFFFFFF,
        24'h202020, 24'h881400, 24'hE45C10, 24'hF8B800,
        24'h3CBCFC, 24'h00A800, 24'hB8F818, 24'h7C7C7C
    };

    // Per-frame sprite state captured at frame_start.
    typedef struct packed {
        logic [9:0] pos_x;
        logic [9:0] pos_y;
        logic       flip;
        logic [1:0] frame;
        logic       visible;
    } mario_state_t;

    // Sprite image: a diagonal colour ramp that shifts by 4 palette
    // entries per animation frame. The anti-diagonal where the sum wraps
    // to 0 gives transparent pixels inside the sprite box.
    function automatic pal_idx_t sprite_pixel(input int frame, input int row, input int col);
        return pal_idx_t'(col + row + 4 * frame + 1);
    endfunction

endpackage

// File: rtl/mario_sprite_rom.sv
// Synchronous single-port sprite ROM, NUM_FRAMES*SPR_W*SPR_H entries of 4-bit palette index.
// Latency: 1 cycle from addr_i to data_o.
// Backpressure: none; a new address is accepted every cycle.
module mario_sprite_rom
    import sprite_pkg::*;
#(
    parameter int SPR_W      = SPR_W_DEF,
    parameter int SPR_H      = SPR_H_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF,
    localparam int XW = $clog2(SPR_W),
    localparam int YW = $clog2(SPR_H),
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int AW = FW + YW + XW
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [AW-1:0] addr_i,
    output pal_idx_t      data_o
);

    pal_idx_t data_q;
    pal_idx_t data_d;

    // Address is {frame, row, col}; the image content is a fixed pattern.
    always_comb begin
        data_d = sprite_pixel(int'(addr_i[AW-1:XW+YW]),
                              int'(addr_i[XW+YW-1:XW]),
                              int'(addr_i[XW-1:0]));
    end

    // Registered read port.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q <= TRANSPARENT_IDX;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/mario_sprite_fetch.sv
// Per-pixel Mario sprite hit test and colour fetch, upstream of color_mapper.
// Latency: LATENCY (2) cycles from DrawX/DrawY to mario/mario_pic_out/DrawX_o/DrawY_o.
// Backpressure: none; one pixel per cycle, never stalls.
module mario_sprite_fetch
    import sprite_pkg::*;
#(
    parameter int SPR_W      = SPR_W_DEF,
    parameter int SPR_H      = SPR_H_DEF,
    parameter int NUM_FRAMES = NUM_FRAMES_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  mario_x,
    input  logic [9:0]  mario_y,
    input  logic        mario_flip,
    input  logic [1:0]  mario_frame,
    input  logic        mario_visible,
    output logic        mario,
    output logic [23:0] mario_pic_out,
    output logic [9:0]  DrawX_o,
    output logic [9:0]  DrawY_o
);

    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int AW = FW + YW + XW;

    // ---------------- Frame latch ----------------
    mario_state_t state_q;
    mario_state_t state_d;

    // Game state is only sampled on frame_start so the sprite cannot tear mid-scan.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d.pos_x   = mario_x;
            state_d.pos_y   = mario_y;
            state_d.flip    = mario_flip;
            state_d.frame   = mario_frame;
            state_d.visible = mario_visible;
        end
    end

    // Shadow state register; reset leaves the sprite hidden until the next frame_start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- Stage 0: hit test and address ----------------
    logic [10:0]   draw_x11, draw_y11;
    logic [10:0]   pos_x11, pos_y11;
    logic [10:0]   end_x11, end_y11;
    logic          hit_x, hit_y;
    logic          in_box_s0;
    logic [XW-1:0] dx_lo, col_s0;
    logic [YW-1:0] dy_lo;
    logic [FW-1:0] frame_eff;
    logic [AW-1:0] addr_s0;

    // Compares are done in 11 bits so a sprite hanging off the right or
    // bottom edge clips instead of wrapping to column/row 0. Only the low
    // bits of dx/dy are needed: inside the box they equal the full difference.
    always_comb begin
        draw_x11  = {1'b0, DrawX};
        draw_y11  = {1'b0, DrawY};
        pos_x11   = {1'b0, state_q.pos_x};
        pos_y11   = {1'b0, state_q.pos_y};
        end_x11   = pos_x11 + 11'(SPR_W);
        end_y11   = pos_y11 + 11'(SPR_H);
        hit_x     = (draw_x11 >= pos_x11) && (draw_x11 < end_x11);
        hit_y     = (draw_y11 >= pos_y11) && (draw_y11 < end_y11);
        in_box_s0 = hit_x && hit_y && state_q.visible;

        dx_lo     = DrawX[XW-1:0] - state_q.pos_x[XW-1:0];
        dy_lo     = DrawY[YW-1:0] - state_q.pos_y[YW-1:0];
        col_s0    = state_q.flip ? (XW'(SPR_W - 1) - dx_lo) : dx_lo;

        // An out-of-range animation frame falls back to frame 0.
        frame_eff = (32'(state_q.frame) < NUM_FRAMES) ? FW'(state_q.frame) : '0;
        addr_s0   = {frame_eff, dy_lo, col_s0};
    end

    // ---------------- Stage 1: ROM read ----------------
    pal_idx_t idx_s1;
    logic     in_box_s1_q;

    mario_sprite_rom #(
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .NUM_FRAMES (NUM_FRAMES)
    ) u_rom (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .addr_i  (addr_s0),
        .data_o  (idx_s1)
    );

    // Carry the in-box flag alongside the ROM read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_box_s1_q <= 1'b0;
        end else begin
            in_box_s1_q <= in_box_s0;
        end
    end

    // ---------------- Stage 2: palette lookup ----------------
    logic mario_d, mario_q;
    rgb_t pic_d, pic_q;

    // Transparent or out-of-box pixels produce no hit and black.
    always_comb begin
        mario_d = in_box_s1_q && (idx_s1 != TRANSPARENT_IDX);
        pic_d   = mario_d ? PALETTE[idx_s1] : '0;
    end

    // Registered colour outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mario_q <= 1'b0;
            pic_q   <= '0;
        end else begin
            mario_q <= mario_d;
            pic_q   <= pic_d;
        end
    end

    // ---------------- Scan position delay line ----------------
    logic [LATENCY-1:0][19:0] pos_dly_q;

    // DrawY/DrawX shifted LATENCY stages to stay aligned with the colour.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_dly_q <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                pos_dly_q[i] <= pos_dly_q[i-1];
            end
            pos_dly_q[0] <= {DrawY, DrawX};
        end
    end

    assign mario         = mario_q;
    assign mario_pic_out = pic_q;
    assign DrawX_o       = pos_dly_q[LATENCY-1][9:0];
    assign DrawY_o       = pos_dly_q[LATENCY-1][19:10];

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Scoreboard bench for mario_sprite_fetch: directed pixels with hand-computed colours.
// Latency: expects outputs exactly 2 cycles after each driven pixel.
// Backpressure: none; one pixel per cycle.
module tb_mario_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [9:0]  mario_x = '0;
    logic [9:0]  mario_y = '0;
    logic        mario_flip = 1'b0;
    logic [1:0]  mario_frame = '0;
    logic        mario_visible = 1'b0;
    logic        mario;
    logic [23:0] mario_pic_out;
    logic [9:0]  DrawX_o;
    logic [9:0]  DrawY_o;

    mario_sprite_fetch dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_start   (frame_start),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .mario_x       (mario_x),
        .mario_y       (mario_y),
        .mario_flip    (mario_flip),
        .mario_frame   (mario_frame),
        .mario_visible (mario_visible),
        .mario         (mario),
        .mario_pic_out (mario_pic_out),
        .DrawX_o       (DrawX_o),
        .DrawY_o       (DrawY_o)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          due;
        logic        m;
        logic [23:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: pops every expectation that is due this cycle and compares.
    always @(negedge Clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin : pop_one
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (e.due != cyc || mario !== e.m || mario_pic_out !== e.rgb ||
                DrawX_o !== e.x || DrawY_o !== e.y) begin
                errors++;
                $display("FAIL %s: got mario=%0b rgb=%06h xo=%0d yo=%0d (cycle %0d), want mario=%0b rgb=%06h xo=%0d yo=%0d (cycle %0d)",
                         e.name, mario, mario_pic_out, DrawX_o, DrawY_o, cyc,
                         e.m, e.rgb, e.x, e.y, e.due);
            end
        end
    end

    // Drive one pixel and queue its expected output two cycles later.
    task automatic pix(input int x, input int y, input logic em, input logic [23:0] ergb,
                       input logic fs, input string nm);
        exp_t e;
        @(negedge Clk);
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        frame_start = fs;
        e.due  = cyc + 2;
        e.m    = em;
        e.rgb  = ergb;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Present new game state and pulse frame_start for one cycle.
    task automatic latch(input int x, input int y, input logic fl, input int fr, input logic vis);
        @(negedge Clk);
        mario_x       = 10'(x);
        mario_y       = 10'(y);
        mario_flip    = fl;
        mario_frame   = 2'(fr);
        mario_visible = vis;
        frame_start   = 1'b1;
        @(negedge Clk);
        frame_start   = 1'b0;
    endtask

    // Let the pipeline empty; a non-empty scoreboard afterwards is an error.
    task automatic drain(input string nm);
        repeat (4) @(negedge Clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: scoreboard still holds %0d entries, want 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int rows[4] = '{0, 200, 207, 479};

    initial begin
        // Inputs describe a visible sprite, but nothing is latched yet.
        mario_x = 10'd100; mario_y = 10'd200; mario_visible = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_mario", 32'(mario), 32'd0);
        chk("rst_pic",   32'(mario_pic_out), 32'd0);
        chk("rst_xo",    32'(DrawX_o), 32'd0);
        chk("rst_yo",    32'(DrawY_o), 32'd0);
        Reset_n = 1'b1;

        // Scan without frame_start: no sprite anywhere, positions lag by 2.
        foreach (rows[r]) begin
            for (int x = 0; x < 1024; x++) pix(x, rows[r], 1'b0, 24'h0, 1'b0, "noframe");
        end
        drain("noframe_drain");

        // Plain sprite at (100,200), frame 0.
        latch(100, 200, 1'b0, 0, 1'b1);
        pix(100, 200, 1'b1, 24'hF83800, 1'b0, "a_origin");
        pix(107, 203, 1'b1, 24'hF8B800, 1'b0, "a_mid");
        pix(115, 215, 1'b1, 24'h7C7C7C, 1'b0, "a_corner");
        pix(115, 200, 1'b0, 24'h0,      1'b0, "a_transp");
        pix(101, 214, 1'b0, 24'h0,      1'b0, "a_transp2");
        pix(116, 200, 1'b0, 24'h0,      1'b0, "a_right_out");
        pix(100, 216, 1'b0, 24'h0,      1'b0, "a_below_out");
        pix(99,  200, 1'b0, 24'h0,      1'b0, "a_left_out");
        pix(100, 199, 1'b0, 24'h0,      1'b0, "a_above_out");

        // Mirrored.
        latch(100, 200, 1'b1, 0, 1'b1);
        pix(100, 201, 1'b1, 24'hF83800, 1'b0, "flip_col15");
        pix(115, 201, 1'b1, 24'hFFA044, 1'b0, "flip_col0");
        pix(100, 200, 1'b0, 24'h0,      1'b0, "flip_transp");
        pix(107, 203, 1'b1, 24'h3CBCFC, 1'b0, "flip_mid");

        // Animation frame 2.
        latch(100, 200, 1'b0, 2, 1'b1);
        pix(100, 200, 1'b1, 24'h881400, 1'b0, "fr2_origin");
        pix(103, 202, 1'b1, 24'hB8F818, 1'b0, "fr2_mid");
        pix(115, 200, 1'b1, 24'h202020, 1'b0, "fr2_col15");

        // Right-edge clipping.
        latch(1020, 200, 1'b0, 0, 1'b1);
        pix(1020, 200, 1'b1, 24'hF83800, 1'b0, "xclip_1020");
        pix(1023, 200, 1'b1, 24'h0058F8, 1'b0, "xclip_1023");
        pix(1023, 215, 1'b1, 24'hAC7C00, 1'b0, "xclip_1023_r15");
        for (int x = 0; x < 12; x++) pix(x, 200, 1'b0, 24'h0, 1'b0, "xclip_nowrap");
        pix(0, 215, 1'b0, 24'h0, 1'b0, "xclip_nowrap_r15");

        // Bottom-edge clipping.
        latch(100, 1020, 1'b0, 0, 1'b1);
        pix(100, 1020, 1'b1, 24'hF83800, 1'b0, "yclip_1020");
        pix(100, 1023, 1'b1, 24'h0058F8, 1'b0, "yclip_1023");
        pix(100, 0,    1'b0, 24'h0,      1'b0, "yclip_nowrap0");
        pix(100, 3,    1'b0, 24'h0,      1'b0, "yclip_nowrap3");

        // Input change without frame_start has no effect until the next pulse.
        latch(100, 200, 1'b0, 0, 1'b1);
        @(negedge Clk);
        mario_x = 10'd300;
        pix(100, 200, 1'b1, 24'hF83800, 1'b0, "hold_old_pos");
        pix(300, 200, 1'b0, 24'h0,      1'b0, "hold_new_pos");
        latch(300, 200, 1'b0, 0, 1'b1);
        pix(300, 200, 1'b1, 24'hF83800, 1'b0, "moved_new_pos");
        pix(100, 200, 1'b0, 24'h0,      1'b0, "moved_old_pos");

        // frame_start coincident with an in-box pixel: old state for that pixel.
        mario_x = 10'd100;
        pix(300, 200, 1'b1, 24'hF83800, 1'b1, "coinc_same_cycle");
        pix(300, 200, 1'b0, 24'h0,      1'b0, "coinc_next_old");
        pix(100, 200, 1'b1, 24'hF83800, 1'b0, "coinc_next_new");

        // Hidden sprite.
        latch(100, 200, 1'b0, 0, 1'b0);
        pix(100, 200, 1'b0, 24'h0, 1'b0, "invisible");
        pix(107, 203, 1'b0, 24'h0, 1'b0, "invisible_mid");
        drain("mid_drain");

        // Reset in the middle of an opaque pixel.
        latch(100, 200, 1'b0, 0, 1'b1);
        pix(100, 200, 1'b1, 24'hF83800, 1'b0, "pre_reset");
        drain("pre_reset_drain");
        chk("hold_mario", 32'(mario), 32'd1);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_mario", 32'(mario), 32'd0);
        chk("async_rst_pic",   32'(mario_pic_out), 32'd0);
        chk("async_rst_xo",    32'(DrawX_o), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        pix(100, 200, 1'b0, 24'h0, 1'b0, "post_rst_hidden");
        pix(107, 203, 1'b0, 24'h0, 1'b0, "post_rst_hidden_mid");
        latch(100, 200, 1'b0, 0, 1'b1);
        pix(100, 200, 1'b1, 24'hF83800, 1'b0, "post_rst_relatched");
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
